secd_sba_preload_ctrl: RTL and testbench
========================================

Name: secd_sba_preload_ctrl

Overview:
Hardware sequencer that drives the security-island debug module over its DMI request/response port. It preloads a word stream into target memory via system-bus access (SBA) and then optionally wakes the core at a given PC by halting it, writing DPC and resuming. It sits between a boot/loader master (word stream plus control) and the DMI port of the debug module, replacing JTAG-driven preload.

Parameters:
- PollTimeout, 1024: maximum status-read polls per wait before an error is raised.
- AddrWidth, 32: width of the target base address and the PC.
- DmiAddrWidth, 7: DMI address width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  pulse; begins a job; ignored while busy_o=1
- base_addr_i  in  AddrWidth  first SBA byte address; sampled at start
- wake_i  in  1  perform wake sequence after preload; sampled at start
- pc_i  in  AddrWidth  resume PC; sampled at start
- word_valid_i  in  1  stream word valid
- word_ready_o  out  1  stream word accepted
- word_data_i  in  32  data word
- word_last_i  in  1  final word of job
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle pulse at job end (success or error)
- error_o  out  1  sticky error; cleared at next accepted start
- err_code_o  out  3  0 none, 1 sberror, 2 timeout, 3 DMI op failed
- dmi_req_valid_o  out  1  DMI request valid
- dmi_req_ready_i  in  1  DMI request ready
- dmi_req_addr_o  out  DmiAddrWidth  DMI register address
- dmi_req_op_o  out  2  1 = read, 2 = write
- dmi_req_data_o  out  32  write data
- dmi_resp_valid_i  in  1  response valid
- dmi_resp_ready_o  out  1  tied 1 whenever a response is awaited
- dmi_resp_data_i  in  32  read data
- dmi_resp_resp_i  in  2  0 = success; nonzero = failed

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- Asynchronous reset mid-job aborts immediately. No DMI request is completed or replayed.
- DMI transaction:
  - Hold valid, addr, op and data stable until dmi_req_ready_i is sampled high.
  - Then wait for dmi_resp_valid_i.
  - Only one transaction may be outstanding.
  - A nonzero dmi_resp_resp_i goes to ERR with code 3.
- POLL(reg, cond): repeatedly read reg until cond holds.
  - Each read increments a poll counter; the counter is cleared on entry.
  - When the counter reaches PollTimeout, go to ERR with code 2.
- Sequence (each arrow is one transaction or wait):
  - IDLE --start--> INIT: write DMControl(0x10)=0x0000_0001.
  - POLL SBCS(0x38): sbbusy(bit21)=0.
  - CFG: write SBCS=0x0005_0000 (sbaccess=2, sbautoincrement=1) → POLL SBCS.
  - ADDR: write SBAddress0(0x39)=base_addr → POLL SBCS.
  - DATA:
    - word_ready_o=1 for exactly one cycle per word, only in the state awaiting a word.
    - On acceptance, write SBData0(0x3C)=word → POLL SBCS.
    - If sberror(bits 14:12)≠0, go to ERR with code 1.
    - Repeat until the accepted word carried word_last_i.
    - A word stream that stalls is waited on indefinitely (no timeout).
  - If wake_i=0, go to FIN. Otherwise:
    - W_D0: write Data0(0x04)=pc.
    - W_HALT: write DMControl=0x8000_0001 → POLL DMStatus(0x11) bit8=1.
    - W_CLR: write DMControl=0x0000_0001.
    - W_CMD: write Command(0x17)=0x0023_07B1 (access register, aarsize=2, transfer, write, DPC).
    - W_RES: write DMControl=0x4000_0001.
    - W_END: write DMControl=0x0000_0001 → FIN.
- FIN: done_o=1 for one cycle → IDLE.
- ERR: error_o=1, err_code_o latched, done_o=1 for one cycle → IDLE. Never issue further DMI requests after an error.
- busy_o=1 in every state except IDLE.
- SBA address auto-increments in the debug module; the block never rewrites SBAddress0 within a job.
- Zero-word job is not supported: the first accepted word with last=1 gives a one-word job.
- start_i and done_o coinciding in the same cycle: start is ignored (busy_o still 1).

Decomposition:
- Package secd_preload_pkg:
  - DMI register address localparams (DMControl, DMStatus, Data0, Command, SBCS, SBAddress0, SBData0).
  - dmi_op_e enum.
  - SBCS field bit positions.
  - Command constant and DMControl constants.
  - err_code_e enum.
  - FSM state enum.
- Sub-module secd_dmi_xact: single-transaction issuer with request/response handshake, response-error flag, and read-data capture. The main FSM sequences calls into it.

Test Plan:
- 3-word job, base 0x1000_0000, data A/B/C, debug-module model with ready delays 0–3 → DMI writes in exact order DMControl, SBCS, SBAddress0, 3×SBData0; done pulse; error_o=0.
- SBCS model returns sbbusy=1 for 5 polls after each write → 6 SBCS reads per wait; data order preserved.
- sberror=3'b010 after word 2 of 4 → error_o=1, err_code_o=1, no further DMI requests, word 3 never accepted.
- DMStatus never halts, PollTimeout=8 → exactly 8 DMStatus reads, err_code_o=2.
- wake_i=1, pc=0x2000_0080 → Data0=0x2000_0080, then DMControl 0x8000_0001, 0x0000_0001, Command 0x0023_07B1, 0x4000_0001, 0x0000_0001; done pulse.
- Assert rst_ni during DATA with dmi_req_valid_o=1 → all outputs 0 asynchronously; a new start_i then runs a clean job from INIT.

Source files
------------

// File: rtl/secd_preload_pkg.sv
// Shared constants and types for the SBA preload sequencer and its DMI issuer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package secd_preload_pkg;

    // Debug-module register addresses on the DMI bus.
    localparam logic [6:0] DMI_DATA0      = 7'h04;
    localparam logic [6:0] DMI_DMCONTROL  = 7'h10;
    localparam logic [6:0] DMI_DMSTATUS   = 7'h11;
    localparam logic [6:0] DMI_COMMAND    = 7'h17;
    localparam logic [6:0] DMI_SBCS       = 7'h38;
    localparam logic [6:0] DMI_SBADDRESS0 = 7'h39;
    localparam logic [6:0] DMI_SBDATA0    = 7'h3C;

    typedef enum logic [1:0] {
        DMI_OP_NOP   = 2'd0,
        DMI_OP_READ  = 2'd1,
        DMI_OP_WRITE = 2'd2
    } dmi_op_e;

    // SBCS / DMStatus field positions.
    localparam int SBCS_SBBUSY_BIT     = 21;
    localparam int SBCS_SBERROR_LSB    = 12;
    localparam int SBCS_SBERROR_MSB    = 14;
    localparam int DMSTATUS_HALTED_BIT = 8;

    // sbaccess=2 (32-bit), sbautoincrement=1.
    localparam logic [31:0] SBCS_CFG_VAL    = 32'h0005_0000;
    // Access register: aarsize=2, transfer, write, regno=DPC.
    localparam logic [31:0] CMD_WRITE_DPC   = 32'h0023_07B1;
    localparam logic [31:0] DMCTL_ACTIVE    = 32'h0000_0001;
    localparam logic [31:0] DMCTL_HALTREQ   = 32'h8000_0001;
    localparam logic [31:0] DMCTL_RESUMEREQ = 32'h4000_0001;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_SBERROR = 3'd1,
        ERR_TIMEOUT = 3'd2,
        ERR_DMI     = 3'd3
    } err_code_e;

    typedef enum logic [3:0] {
        ST_IDLE, ST_INIT, ST_POLL_SB, ST_CFG, ST_ADDR, ST_WAIT_WORD, ST_DATA,
        ST_W_D0, ST_W_HALT, ST_POLL_HALT, ST_W_CLR, ST_W_CMD, ST_W_RES,
        ST_W_END, ST_FIN, ST_ERR
    } state_e;

    typedef enum logic [1:0] {
        X_IDLE, X_REQ, X_RSP
    } xact_state_e;

endpackage

// File: rtl/secd_dmi_xact.sv
// Issues one DMI transaction at a time and reports its outcome.
// Latency: request 1 cycle after req_i, done_o 1 cycle after the response beat.
// Backpressure: request held stable until dmi_req_ready_i; waits indefinitely for the response.
module secd_dmi_xact
    import secd_preload_pkg::*;
#(
    parameter int DmiAddrWidth = 7
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    input  logic [DmiAddrWidth-1:0] addr_i,
    input  dmi_op_e                 op_i,
    input  logic [31:0]             data_i,
    output logic                    done_o,
    output logic                    err_o,
    output logic [31:0]             rdata_o,
    output logic                    dmi_req_valid_o,
    input  logic                    dmi_req_ready_i,
    output logic [DmiAddrWidth-1:0] dmi_req_addr_o,
    output logic [1:0]              dmi_req_op_o,
    output logic [31:0]             dmi_req_data_o,
    input  logic                    dmi_resp_valid_i,
    output logic                    dmi_resp_ready_o,
    input  logic [31:0]             dmi_resp_data_i,
    input  logic [1:0]              dmi_resp_resp_i
);

    xact_state_e             state_q, state_d;
    logic [DmiAddrWidth-1:0] addr_q;
    dmi_op_e                 op_q;
    logic [31:0]             data_q;
    logic                    done_q, err_q;
    logic [31:0]             rdata_q;
    logic                    resp_beat;

    assign resp_beat = (state_q == X_RSP) && dmi_resp_valid_i;

    // Next state: accept when idle, move on at the request and response handshakes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            X_IDLE:  if (req_i)            state_d = X_REQ;
            X_REQ:   if (dmi_req_ready_i)  state_d = X_RSP;
            X_RSP:   if (dmi_resp_valid_i) state_d = X_IDLE;
            default:                       state_d = X_IDLE;
        endcase
    end

    // State register, request latch and response capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= X_IDLE;
            addr_q  <= '0;
            op_q    <= DMI_OP_NOP;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == X_IDLE && req_i) begin
                addr_q <= addr_i;
                op_q   <= op_i;
                data_q <= data_i;
            end
            done_q <= resp_beat;
            if (resp_beat) begin
                err_q   <= (dmi_resp_resp_i != 2'b00);
                rdata_q <= dmi_resp_data_i;
            end
        end
    end

    assign dmi_req_valid_o  = (state_q == X_REQ);
    assign dmi_resp_ready_o = (state_q == X_RSP);
    assign dmi_req_addr_o   = addr_q;
    assign dmi_req_op_o     = op_q;
    assign dmi_req_data_o   = data_q;
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign rdata_o          = rdata_q;

endmodule

// File: rtl/secd_sba_preload_ctrl.sv
// Sequences DMI accesses to preload memory over SBA, then optionally halts/sets DPC/resumes.
// Latency: several DMI round trips per word (write SBData0 plus SBCS polls).
// Backpressure: word stream stalls without limit; DMI request/response handshakes stall the FSM.
module secd_sba_preload_ctrl
    import secd_preload_pkg::*;
#(
    parameter int PollTimeout  = 1024,
    parameter int AddrWidth    = 32,
    parameter int DmiAddrWidth = 7
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [AddrWidth-1:0]    base_addr_i,
    input  logic                    wake_i,
    input  logic [AddrWidth-1:0]    pc_i,
    input  logic                    word_valid_i,
    output logic                    word_ready_o,
    input  logic [31:0]             word_data_i,
    input  logic                    word_last_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [2:0]              err_code_o,
    output logic                    dmi_req_valid_o,
    input  logic                    dmi_req_ready_i,
    output logic [DmiAddrWidth-1:0] dmi_req_addr_o,
    output logic [1:0]              dmi_req_op_o,
    output logic [31:0]             dmi_req_data_o,
    input  logic                    dmi_resp_valid_i,
    output logic                    dmi_resp_ready_o,
    input  logic [31:0]             dmi_resp_data_i,
    input  logic [1:0]              dmi_resp_resp_i
);

    localparam int CntW = $clog2(PollTimeout + 1);

    state_e                 state_q, state_d, ret_q, ret_d;
    logic                   issued_q, issued_d;
    logic [CntW-1:0]        poll_cnt_q, poll_cnt_d, poll_next;
    logic [AddrWidth-1:0]   base_q, base_d, pc_q, pc_d;
    logic                   wake_q, wake_d, last_q, last_d, error_q, error_d;
    logic [31:0]            word_q, word_d;
    err_code_e              err_code_q, err_code_d;

    logic                    x_req, x_done, x_err, xact_st;
    logic [6:0]              reg_addr;
    dmi_op_e                 x_op;
    logic [31:0]             x_data, x_rdata;
    logic                    unused_rdata;

    assign unused_rdata = ^x_rdata;
    assign poll_next    = poll_cnt_q + 1'b1;

    secd_dmi_xact #(.DmiAddrWidth(DmiAddrWidth)) u_xact (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .req_i            (x_req),
        .addr_i           (DmiAddrWidth'(reg_addr)),
        .op_i             (x_op),
        .data_i           (x_data),
        .done_o           (x_done),
        .err_o            (x_err),
        .rdata_o          (x_rdata),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_ready_i  (dmi_req_ready_i),
        .dmi_req_addr_o   (dmi_req_addr_o),
        .dmi_req_op_o     (dmi_req_op_o),
        .dmi_req_data_o   (dmi_req_data_o),
        .dmi_resp_valid_i (dmi_resp_valid_i),
        .dmi_resp_ready_o (dmi_resp_ready_o),
        .dmi_resp_data_i  (dmi_resp_data_i),
        .dmi_resp_resp_i  (dmi_resp_resp_i)
    );

    // Next state: each transactional state issues once, then branches on the outcome.
    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        issued_d   = issued_q;
        poll_cnt_d = poll_cnt_q;
        base_d     = base_q;
        pc_d       = pc_q;
        wake_d     = wake_q;
        word_d     = word_q;
        last_d     = last_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        x_req      = 1'b0;
        x_op       = DMI_OP_WRITE;
        reg_addr   = DMI_DMCONTROL;
        x_data     = DMCTL_ACTIVE;
        xact_st    = 1'b1;

        case (state_q)
            ST_INIT, ST_W_CLR, ST_W_END: begin reg_addr = DMI_DMCONTROL;  x_data = DMCTL_ACTIVE;    end
            ST_POLL_SB:   begin reg_addr = DMI_SBCS;       x_op = DMI_OP_READ; x_data = '0; end
            ST_CFG:       begin reg_addr = DMI_SBCS;       x_data = SBCS_CFG_VAL;           end
            ST_ADDR:      begin reg_addr = DMI_SBADDRESS0; x_data = 32'(base_q);            end
            ST_DATA:      begin reg_addr = DMI_SBDATA0;    x_data = word_q;                 end
            ST_W_D0:      begin reg_addr = DMI_DATA0;      x_data = 32'(pc_q);              end
            ST_W_HALT:    begin reg_addr = DMI_DMCONTROL;  x_data = DMCTL_HALTREQ;          end
            ST_POLL_HALT: begin reg_addr = DMI_DMSTATUS;   x_op = DMI_OP_READ; x_data = '0; end
            ST_W_CMD:     begin reg_addr = DMI_COMMAND;    x_data = CMD_WRITE_DPC;          end
            ST_W_RES:     begin reg_addr = DMI_DMCONTROL;  x_data = DMCTL_RESUMEREQ;        end
            default:      xact_st = 1'b0;
        endcase

        if (xact_st) begin
            if (!issued_q) begin
                x_req    = 1'b1;
                issued_d = 1'b1;
            end else if (x_done) begin
                issued_d = 1'b0;
                if (x_err) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_DMI;
                end else begin
                    case (state_q)
                        ST_INIT: begin state_d = ST_POLL_SB; ret_d = ST_CFG;       poll_cnt_d = '0; end
                        ST_CFG:  begin state_d = ST_POLL_SB; ret_d = ST_ADDR;      poll_cnt_d = '0; end
                        ST_ADDR, ST_DATA:
                                 begin state_d = ST_POLL_SB; ret_d = ST_WAIT_WORD; poll_cnt_d = '0; end
                        ST_POLL_SB: begin
                            poll_cnt_d = poll_next;
                            if (!x_rdata[SBCS_SBBUSY_BIT]) begin
                                if (x_rdata[SBCS_SBERROR_MSB:SBCS_SBERROR_LSB] != 3'b000) begin
                                    state_d    = ST_ERR;
                                    err_code_d = ERR_SBERROR;
                                end else if (ret_q == ST_WAIT_WORD && last_q) begin
                                    state_d = wake_q ? ST_W_D0 : ST_FIN;
                                end else begin
                                    state_d = ret_q;
                                end
                            end else if (poll_next >= CntW'(PollTimeout)) begin
                                state_d    = ST_ERR;
                                err_code_d = ERR_TIMEOUT;
                            end
                        end
                        ST_W_D0:   state_d = ST_W_HALT;
                        ST_W_HALT: begin state_d = ST_POLL_HALT; poll_cnt_d = '0; end
                        ST_POLL_HALT: begin
                            poll_cnt_d = poll_next;
                            if (x_rdata[DMSTATUS_HALTED_BIT]) begin
                                state_d = ST_W_CLR;
                            end else if (poll_next >= CntW'(PollTimeout)) begin
                                state_d    = ST_ERR;
                                err_code_d = ERR_TIMEOUT;
                            end
                        end
                        ST_W_CLR: state_d = ST_W_CMD;
                        ST_W_CMD: state_d = ST_W_RES;
                        ST_W_RES: state_d = ST_W_END;
                        ST_W_END: state_d = ST_FIN;
                        default:  state_d = ST_ERR;
                    endcase
                end
            end
        end else begin
            case (state_q)
                ST_IDLE: if (start_i) begin
                    base_d     = base_addr_i;
                    pc_d       = pc_i;
                    wake_d     = wake_i;
                    last_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                    state_d    = ST_INIT;
                end
                // Ready is held while waiting, so each word sees exactly one accepting cycle.
                ST_WAIT_WORD: if (word_valid_i) begin
                    word_d  = word_data_i;
                    last_d  = word_last_i;
                    state_d = ST_DATA;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (state_d == ST_ERR && state_q != ST_ERR) error_d = 1'b1;
    end

    // Sequencer state and job context registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            ret_q      <= ST_IDLE;
            issued_q   <= 1'b0;
            poll_cnt_q <= '0;
            base_q     <= '0;
            pc_q       <= '0;
            wake_q     <= 1'b0;
            word_q     <= '0;
            last_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            issued_q   <= issued_d;
            poll_cnt_q <= poll_cnt_d;
            base_q     <= base_d;
            pc_q       <= pc_d;
            wake_q     <= wake_d;
            word_q     <= word_d;
            last_q     <= last_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
        end
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_FIN) || (state_q == ST_ERR);
    assign word_ready_o = (state_q == ST_WAIT_WORD);
    assign error_o      = error_q;
    assign err_code_o   = err_code_q;

endmodule

// File: tb/tb_secd_sba_preload_ctrl.sv
// Scoreboard bench: debug-module model on DMI, word-stream driver, done monitor.
// Latency: n/a.
// Backpressure: model inserts 0-3 cycle request-ready delays.
module tb_secd_sba_preload_ctrl;

    localparam int PT = 8;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start = 1'b0, wake = 1'b0;
    logic [31:0] base_addr = '0, pc_v = '0;
    logic        word_valid = 1'b0, word_last = 1'b0, word_ready;
    logic [31:0] word_data = '0;
    logic        busy_o, done_o, error_o;
    logic [2:0]  err_code_o;
    logic        dmi_req_valid, dmi_req_ready = 1'b0;
    logic [6:0]  dmi_req_addr;
    logic [1:0]  dmi_req_op;
    logic [31:0] dmi_req_data;
    logic        dmi_resp_valid = 1'b0, dmi_resp_ready;
    logic [31:0] dmi_resp_data = '0;
    logic [1:0]  dmi_resp_resp = '0;

    always #5 clk = ~clk;

    secd_sba_preload_ctrl #(.PollTimeout(PT), .AddrWidth(32), .DmiAddrWidth(7)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base_addr),
        .wake_i(wake), .pc_i(pc_v), .word_valid_i(word_valid), .word_ready_o(word_ready),
        .word_data_i(word_data), .word_last_i(word_last), .busy_o(busy_o), .done_o(done_o),
        .error_o(error_o), .err_code_o(err_code_o), .dmi_req_valid_o(dmi_req_valid),
        .dmi_req_ready_i(dmi_req_ready), .dmi_req_addr_o(dmi_req_addr), .dmi_req_op_o(dmi_req_op),
        .dmi_req_data_o(dmi_req_data), .dmi_resp_valid_i(dmi_resp_valid),
        .dmi_resp_ready_o(dmi_resp_ready), .dmi_resp_data_i(dmi_resp_data),
        .dmi_resp_resp_i(dmi_resp_resp)
    );

    typedef struct packed { logic [6:0] a; logic [31:0] d; } wr_t;
    typedef struct packed { logic e; logic [2:0] c; } dn_t;
    wr_t exp_wr[$];
    dn_t exp_dn[$];
    int  n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    function automatic logic [63:0] outs();
        return {14'b0, busy_o, done_o, error_o, err_code_o, word_ready, dmi_req_valid,
                dmi_req_addr, dmi_req_op, dmi_req_data, dmi_resp_ready};
    endfunction

    // ---------------- debug-module model and DMI write scoreboard ----------------
    int          m_ph = 0, m_dly = 0, dly_idx = 0;
    bit          m_seen = 0;
    logic [6:0]  m_a;
    logic [1:0]  m_op;
    logic [31:0] m_d;
    int          busy_polls, busy_left, sberr_after, word_cnt, fail_n;
    logic [2:0]  sberr;
    bit          halt_never;
    int          sbcs_reads, dms_reads, req_total;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_ph = 0; m_seen = 0; dmi_req_ready = 1'b0; dmi_resp_valid = 1'b0;
        end else begin
            case (m_ph)
                0: if (dmi_req_valid) begin
                    if (m_seen) chk("req_hold", {dmi_req_addr, dmi_req_op, dmi_req_data}, {m_a, m_op, m_d});
                    m_a = dmi_req_addr; m_op = dmi_req_op; m_d = dmi_req_data; m_seen = 1;
                    if (m_dly == 0) begin dmi_req_ready = 1'b1; m_ph = 1; end
                    else m_dly--;
                end
                1: begin
                    wr_t w;
                    dmi_req_ready = 1'b0; m_seen = 0; req_total++;
                    chk("req_op_legal", (m_op == 2'd1 || m_op == 2'd2), 1);
                    dmi_resp_data = '0;
                    if (m_op == 2'd2) begin
                        if (exp_wr.size() == 0) begin
                            n_cmp++; n_bad++;
                            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required none", m_a, m_d);
                        end else begin
                            w = exp_wr.pop_front();
                            chk("wr_addr", m_a, w.a);
                            chk("wr_data", m_d, w.d);
                        end
                        busy_left = busy_polls;
                        if (m_a == 7'h3C) begin
                            word_cnt++;
                            if (word_cnt == sberr_after) sberr = 3'b010;
                        end
                    end else if (m_a == 7'h38) begin
                        sbcs_reads++;
                        dmi_resp_data = ((busy_left > 0) ? 32'h0020_0000 : 32'h0) | {17'b0, sberr, 12'b0};
                        if (busy_left > 0) busy_left--;
                    end else if (m_a == 7'h11) begin
                        dms_reads++;
                        dmi_resp_data = halt_never ? 32'h0 : 32'h0000_0100;
                    end
                    dmi_resp_resp  = (req_total == fail_n) ? 2'd1 : 2'd0;
                    dmi_resp_valid = 1'b1;
                    m_ph = 2;
                end
                default: begin
                    dmi_resp_valid = 1'b0; dmi_resp_resp = 2'd0; m_ph = 0;
                    dly_idx = (dly_idx + 1) % 4; m_dly = dly_idx;
                end
            endcase
        end
    end

    // ---------------- word-stream driver ----------------
    logic [31:0] wq[$];
    int          w_idx = 0, acc_cnt = 0;
    bit          w_pend = 0;

    always @(negedge clk) begin
        if (w_pend) begin w_idx++; w_pend = 0; end
        if (w_idx < wq.size()) begin
            word_valid = 1'b1; word_data = wq[w_idx]; word_last = (w_idx == wq.size() - 1);
        end else begin
            word_valid = 1'b0; word_last = 1'b0;
        end
        if (word_valid && word_ready) begin w_pend = 1; acc_cnt++; end
    end

    // ---------------- done monitor ----------------
    bit prev_done = 0;
    always @(negedge clk) begin
        if (done_o) begin
            dn_t e;
            chk("done_one_cycle", prev_done, 0);
            if (exp_dn.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_done: got done with code %0d, required none", err_code_o);
            end else begin
                e = exp_dn.pop_front();
                chk("error_flag", error_o, e.e);
                chk("err_code", err_code_o, e.c);
            end
        end
        prev_done = done_o;
    end

    // ---------------- stimulus ----------------
    task automatic cfg(input int bp, input int sa, input bit hn, input int fn);
        busy_polls = bp; sberr_after = sa; halt_never = hn; fail_n = fn;
        busy_left = 0; sberr = 3'b0; word_cnt = 0;
        sbcs_reads = 0; dms_reads = 0; req_total = 0; acc_cnt = 0;
    endtask

    task automatic ew(input logic [6:0] a, input logic [31:0] d);
        exp_wr.push_back({a, d});
    endtask

    task automatic go(input logic [31:0] b, input bit wk, input logic [31:0] pc);
        @(negedge clk);
        start = 1'b1; base_addr = b; wake = wk; pc_v = pc;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy_o, 1);
    endtask

    // Returns at a falling edge with done_o high; optionally pulses start in that same cycle.
    task automatic wait_done(input string nm, input bit start_at_done);
        int t = 0;
        while (!done_o && t < 4000) begin @(negedge clk); t++; end
        if (!done_o) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: got no done after %0d cycles, required done", nm, t);
        end
        if (start_at_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("idle_after_done", busy_o, 0);
        repeat (6) @(negedge clk);
        wq.delete(); w_idx = 0;
        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("done_queue_drained", exp_dn.size(), 0);
    endtask

    task automatic plain_job(input logic [31:0] b, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2);
        ew(7'h10, 32'h1); ew(7'h38, 32'h0005_0000); ew(7'h39, b);
        ew(7'h3C, w0); ew(7'h3C, w1); ew(7'h3C, w2);
        wq = '{w0, w1, w2}; w_idx = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 0);
        rst_n = 1'b1;

        // 3-word job; a start coinciding with done must be ignored.
        cfg(0, 0, 0, 0);
        plain_job(32'h1000_0000, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003);
        exp_dn.push_back({1'b0, 3'd0});
        go(32'h1000_0000, 1'b0, 32'h0);
        wait_done("job3", 1'b1);
        chk("t1_sbcs_reads", sbcs_reads, 6);
        chk("t1_words_accepted", acc_cnt, 3);
        chk("t1_no_req_after_done", req_total, 12);

        // sbbusy held for 5 polls after every write: 6 SBCS reads per wait.
        cfg(5, 0, 0, 0);
        plain_job(32'h0000_2000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
        exp_dn.push_back({1'b0, 3'd0});
        go(32'h0000_2000, 1'b0, 32'h0);
        wait_done("busy", 1'b0);
        chk("t2_sbcs_reads", sbcs_reads, 36);

        // sberror after word 2 of 4.
        cfg(0, 2, 0, 0);
        ew(7'h10, 32'h1); ew(7'h38, 32'h0005_0000); ew(7'h39, 32'h4000_0000);
        ew(7'h3C, 32'hD000_0000); ew(7'h3C, 32'hD000_0001);
        wq = '{32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003}; w_idx = 0;
        exp_dn.push_back({1'b1, 3'd1});
        go(32'h4000_0000, 1'b0, 32'h0);
        wait_done("sberr", 1'b0);
        chk("t3_words_accepted", acc_cnt, 2);
        chk("t3_req_total", req_total, 10);

        // DMStatus never halts: PT reads then timeout.
        cfg(0, 0, 1, 0);
        ew(7'h10, 32'h1); ew(7'h38, 32'h0005_0000); ew(7'h39, 32'h5000_0000);
        ew(7'h3C, 32'h5555_AAAA); ew(7'h04, 32'h3000_0000); ew(7'h10, 32'h8000_0001);
        wq = '{32'h5555_AAAA}; w_idx = 0;
        exp_dn.push_back({1'b1, 3'd2});
        go(32'h5000_0000, 1'b1, 32'h3000_0000);
        wait_done("halt_to", 1'b0);
        chk("t4_dms_reads", dms_reads, PT);
        chk("t4_req_total", req_total, 4 + 4 + PT + 2);
        chk("t4_error_sticky", {error_o, err_code_o}, {1'b1, 3'd2});

        // Wake sequence with pc 0x2000_0080.
        cfg(0, 0, 0, 0);
        ew(7'h10, 32'h1); ew(7'h38, 32'h0005_0000); ew(7'h39, 32'h6000_0000);
        ew(7'h3C, 32'h0BAD_F00D); ew(7'h3C, 32'hCAFE_0001);
        ew(7'h04, 32'h2000_0080); ew(7'h10, 32'h8000_0001); ew(7'h10, 32'h0000_0001);
        ew(7'h17, 32'h0023_07B1); ew(7'h10, 32'h4000_0001); ew(7'h10, 32'h0000_0001);
        wq = '{32'h0BAD_F00D, 32'hCAFE_0001}; w_idx = 0;
        exp_dn.push_back({1'b0, 3'd0});
        go(32'h6000_0000, 1'b1, 32'h2000_0080);
        chk("t5_error_cleared", {error_o, err_code_o}, 0);
        wait_done("wake", 1'b0);
        chk("t5_dms_reads", dms_reads, 1);

        // DMI response failure on the CFG write.
        cfg(0, 0, 0, 3);
        ew(7'h10, 32'h1); ew(7'h38, 32'h0005_0000);
        exp_dn.push_back({1'b1, 3'd3});
        wq = '{32'h7777_7777}; w_idx = 0;
        go(32'h7000_0000, 1'b0, 32'h0);
        wait_done("dmi_fail", 1'b0);
        chk("t7_req_total", req_total, 3);

        // Asynchronous reset during DATA with a request pending.
        cfg(0, 0, 0, 0);
        plain_job(32'h8000_0000, 32'h0000_00E1, 32'h0000_00E2, 32'h0000_00E3);
        go(32'h8000_0000, 1'b0, 32'h0);
        begin
            int t = 0;
            while (!(dmi_req_valid && dmi_req_addr == 7'h3C) && t < 1000) begin @(negedge clk); t++; end
            chk("rst_data_req_seen", (dmi_req_valid && dmi_req_addr == 7'h3C), 1);
        end
        #1 rst_n = 1'b0;
        #1 chk("async_reset_outputs", outs(), 0);
        repeat (2) @(negedge clk);
        exp_wr.delete(); exp_dn.delete(); wq.delete(); w_idx = 0; w_pend = 0;
        rst_n = 1'b1;

        // Clean job after reset starts again from INIT.
        cfg(0, 0, 0, 0);
        plain_job(32'h9000_0000, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F);
        exp_dn.push_back({1'b0, 3'd0});
        go(32'h9000_0000, 1'b0, 32'h0);
        wait_done("post_reset", 1'b0);
        chk("t6_words_accepted", acc_cnt, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
